// File: rtl/wb_pkg.sv
// Shared definitions for the D-side posted write buffer.
// Provides the default line address / line data widths and the
// downstream (memory-side) state machine encoding.
package wb_pkg;

  localparam int WB_ADDR_W = 28;   // line address, byte address bits [31:4]
  localparam int WB_DATA_W = 128;  // one cache line

  // Memory-side sequencer: IDLE picks the next job, DRAIN retires the
  // FIFO head, READ services a read miss, GAP is the mandatory idle cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2,
    GAP   = 2'd3
  } wb_state_e;

endpackage

// File: rtl/dmem_write_buffer_if.sv
// Slow-memory request/ready bus, used on both faces of the write buffer.
//   read, write : request strobes, held by the requester until ready
//   addr, wdata : request line address / write line
//   rdata       : read line, valid while ready is high after a read
//   ready       : one-cycle completion pulse from the responder
// master = requester side, slave = responder side.
interface dmem_write_buffer_if #(
  parameter int ADDR_W = wb_pkg::WB_ADDR_W,
  parameter int DATA_W = wb_pkg::WB_DATA_W
) ();

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (
    output read, write, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  read, write, addr, wdata,
    output rdata, ready
  );

endinterface

// File: rtl/wb_match.sv
// Combinational address compare across the buffer entries.
//   entry_addr : stored line addresses, indexed by physical slot
//   head/count : FIFO window; only slots head .. head+count-1 are valid
//   head_busy  : the head slot is committed to (or already in) a drain
//   addr       : lookup address from the cache
//   hit        : some valid entry matches
//   hit_idx    : physical slot of the youngest matching entry
//   head_only  : the youngest match is the committed head, so a write
//                must not be merged into it
module wb_match #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 28,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic [ADDR_W-1:0] entry_addr [DEPTH],
  input  logic [PTR_W-1:0]  head,
  input  logic [CNT_W-1:0]  count,
  input  logic              head_busy,
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [PTR_W-1:0]  hit_idx,
  output logic              head_only
);

  logic [PTR_W-1:0] idx_s;

  // Walk from oldest to youngest so the last match found is the youngest.
  always_comb begin
    hit     = 1'b0;
    hit_idx = head;
    idx_s   = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (entry_addr[idx_s] == addr)) begin
        hit     = 1'b1;
        hit_idx = idx_s;
      end else begin
        hit     = hit;
        hit_idx = hit_idx;
      end
    end
    // Head is the oldest entry, so a youngest match on it means it is the only match.
    head_only = hit && head_busy && (hit_idx == head);
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// Posted line-granular write buffer between the D-cache and slow memory.
// Cache write-backs are acknowledged in one cycle and drained in the
// background; read hits are forwarded from the buffer (youngest copy);
// read misses go to memory ahead of any further drains.
//   clk   : system clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset, discards all buffered lines
//   c     : cache face (this block is the responder)
//   m     : memory face (this block is the requester)
// All outputs on both faces are registered.
module dmem_write_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dmem_write_buffer_if.slave   c,
  dmem_write_buffer_if.master  m
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;

  wb_state_e         state_r;
  logic              c_ready_r;
  logic [DATA_W-1:0] c_rdata_r;
  logic              m_read_r;
  logic              m_write_r;
  logic [ADDR_W-1:0] m_addr_r;
  logic [DATA_W-1:0] m_wdata_r;
  logic              rd_pend_r;   // read miss waiting for / in memory access
  logic              rd_got_r;    // read miss data captured, ack after GAP
  logic [ADDR_W-1:0] rd_addr_r;

  logic              accept_s;
  logic              wr_s;
  logic              rd_s;
  logic              head_busy_s;
  logic              hit_s;
  logic [PTR_W-1:0]  hit_idx_s;
  logic              head_only_s;
  logic              coal_s;
  logic              app_s;
  logic              rd_hit_s;
  logic              rd_miss_s;
  logic              pop_s;

  assign c.ready = c_ready_r;
  assign c.rdata = c_rdata_r;
  assign m.read  = m_read_r;
  assign m.write = m_write_r;
  assign m.addr  = m_addr_r;
  assign m.wdata = m_wdata_r;

  wb_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .PTR_W  (PTR_W),
    .CNT_W  (CNT_W)
  ) u_match (
    .entry_addr (addr_mem),
    .head       (head_r),
    .count      (count_r),
    .head_busy  (head_busy_s),
    .addr       (c.addr),
    .hit        (hit_s),
    .hit_idx    (hit_idx_s),
    .head_only  (head_only_s)
  );

  // Request decode: which cache operation, if any, completes this cycle.
  always_comb begin
    // The cycle after an ack still shows the old request; a pending miss owns the cache.
    accept_s    = !c_ready_r && !rd_pend_r;
    wr_s        = accept_s && c.write;
    rd_s        = accept_s && c.read;
    // In IDLE with data and no read pending, the head is latched into DRAIN at
    // this edge, so it is already off limits for merging.
    head_busy_s = (state_r == DRAIN) ||
                  ((state_r == IDLE) && !rd_pend_r && (count_r != {CNT_W{1'b0}}));
    coal_s      = wr_s && hit_s && !head_only_s;
    // Fullness uses the registered count: a pop this cycle frees space next cycle.
    app_s       = wr_s && !coal_s && (count_r < FULL_CNT);
    rd_hit_s    = rd_s && hit_s;
    rd_miss_s   = rd_s && !hit_s;
    pop_s       = (state_r == DRAIN) && m.ready;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (app_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({app_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage: append at the tail or merge into an existing line.
  always_ff @(posedge clk) begin
    if (rst_n && app_s) begin
      addr_mem[tail_r] <= c.addr;
      data_mem[tail_r] <= c.wdata;
    end else if (rst_n && coal_s) begin
      data_mem[hit_idx_s] <= c.wdata;
    end
  end

  // Memory-side sequencer plus all registered outputs on both faces.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      c_ready_r <= 1'b0;
      c_rdata_r <= {DATA_W{1'b0}};
      m_read_r  <= 1'b0;
      m_write_r <= 1'b0;
      m_addr_r  <= {ADDR_W{1'b0}};
      m_wdata_r <= {DATA_W{1'b0}};
      rd_pend_r <= 1'b0;
      rd_got_r  <= 1'b0;
      rd_addr_r <= {ADDR_W{1'b0}};
    end else begin
      c_ready_r <= coal_s || app_s || rd_hit_s;
      if (rd_hit_s) begin
        c_rdata_r <= data_mem[hit_idx_s];
      end
      if (rd_miss_s) begin
        rd_pend_r <= 1'b1;
        rd_addr_r <= c.addr;
      end

      case (state_r)
        IDLE: begin
          if (rd_pend_r) begin
            state_r  <= READ;
            m_read_r <= 1'b1;
            m_addr_r <= rd_addr_r;
          end else if (count_r != {CNT_W{1'b0}}) begin
            state_r   <= DRAIN;
            m_write_r <= 1'b1;
            m_addr_r  <= addr_mem[head_r];
            m_wdata_r <= data_mem[head_r];
          end else begin
            state_r <= IDLE;
          end
        end
        DRAIN: begin
          if (m.ready) begin
            state_r   <= GAP;
            m_write_r <= 1'b0;
          end else begin
            state_r <= DRAIN;
          end
        end
        READ: begin
          if (m.ready) begin
            state_r   <= GAP;
            m_read_r  <= 1'b0;
            c_rdata_r <= m.rdata;
            rd_got_r  <= 1'b1;
          end else begin
            state_r <= READ;
          end
        end
        GAP: begin
          state_r <= IDLE;
          if (rd_got_r) begin
            c_ready_r <= 1'b1;
            rd_got_r  <= 1'b0;
            rd_pend_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          m_read_r  <= 1'b0;
          m_write_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Scoreboard bench for dmem_write_buffer: cache-side acks and memory-side
// drains are checked by separate monitor processes against queues filled
// by the directed stimulus.
module tb_dmem_write_buffer;

  typedef struct {
    bit           is_read;
    logic [127:0] data;
  } cexp_t;

  typedef struct {
    logic [27:0]  addr;
    logic [127:0] data;
  } mexp_t;

  logic clk;
  logic rst_n;

  dmem_write_buffer_if cif ();
  dmem_write_buffer_if mif ();

  dmem_write_buffer #(.DEPTH(4), .ADDR_W(28), .DATA_W(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .c     (cif),
    .m     (mif)
  );

  cexp_t cq[$];
  mexp_t mq[$];
  logic [127:0] mem [logic [27:0]];

  int n_tests = 0;
  int n_fail  = 0;
  int mem_lat = 1;
  int writes_done = 0;
  int reads_seen  = 0;
  int w30 = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Cache-side monitor: every ack must match the oldest expected response.
  initial begin
    cexp_t e;
    forever begin
      @(negedge clk);
      if (cif.ready === 1'b1) begin
        n_tests++;
        if (cq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_c_ready: got ack, required none");
        end else begin
          e = cq.pop_front();
          if (e.is_read != cif.read) begin
            n_fail++;
            $display("FAIL ack_kind: got read=%0b, required read=%0b", cif.read, e.is_read);
          end else if (e.is_read && (cif.rdata !== e.data)) begin
            n_fail++;
            $display("FAIL c_rdata: got %0h, required %0h", cif.rdata, e.data);
          end
        end
      end
    end
  end

  // Memory model and memory-side monitor.
  initial begin
    int wait_cnt;
    logic [27:0]  s_addr;
    logic [127:0] s_data;
    mexp_t e;
    wait_cnt = 0;
    s_addr = 28'd0;
    s_data = 128'd0;
    mif.ready = 1'b0;
    mif.rdata = 128'd0;
    forever begin
      @(posedge clk);
      #1;
      mif.ready = 1'b0;
      if (!rst_n) begin
        wait_cnt = 0;
      end else if (mif.write || mif.read) begin
        if (wait_cnt == 0) begin
          s_addr = mif.addr;
          s_data = mif.wdata;
          if (mif.read) reads_seen++;
        end
        wait_cnt++;
        if (wait_cnt >= mem_lat) begin
          wait_cnt = 0;
          mif.ready = 1'b1;
          chk("m_addr_hold", mif.addr, s_addr);
          if (mif.write) begin
            chk("m_wdata_hold", mif.wdata, s_data);
            mem[mif.addr] = mif.wdata;
            writes_done++;
            if (mif.addr == 28'h30) w30++;
            n_tests++;
            if (mq.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_m_write: got %0h/%0h, required none", mif.addr, mif.wdata);
            end else begin
              e = mq.pop_front();
              if ((mif.addr !== e.addr) || (mif.wdata !== e.data)) begin
                n_fail++;
                $display("FAIL m_write_order: got %0h/%0h, required %0h/%0h",
                         mif.addr, mif.wdata, e.addr, e.data);
              end
            end
          end else begin
            mif.rdata = mem.exists(mif.addr) ? mem[mif.addr] : 128'd0;
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Hold a request until ack, then drop it on the edge that samples the ack.
  task automatic cache_req(input bit is_rd, input logic [27:0] a, input logic [127:0] d,
                           output int cyc);
    cyc = 0;
    cif.read  = is_rd;
    cif.write = !is_rd;
    cif.addr  = a;
    cif.wdata = d;
    while (cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cif.ready) break;
    end
    if (!cif.ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_timeout: addr %0h got no ack, required ack within 300", a);
    end
    @(posedge clk);
    #1;
    cif.read  = 1'b0;
    cif.write = 1'b0;
  endtask

  task automatic wr(input logic [27:0] a, input logic [127:0] d, input bit drains, output int cyc);
    cexp_t ce;
    mexp_t me;
    ce.is_read = 1'b0;
    ce.data = 128'd0;
    cq.push_back(ce);
    if (drains) begin
      me.addr = a;
      me.data = d;
      mq.push_back(me);
    end
    cache_req(1'b0, a, d, cyc);
  endtask

  task automatic rd(input logic [27:0] a, input logic [127:0] exp_d, output int cyc);
    cexp_t ce;
    ce.is_read = 1'b1;
    ce.data = exp_d;
    cq.push_back(ce);
    cache_req(1'b1, a, 128'd0, cyc);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((mq.size() != 0 || mif.write || mif.read) && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, (n >= 600) ? 1 : 0, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int base;
    int rbase;
    int n;
    rst_n = 1'b0;
    cif.read = 1'b0;
    cif.write = 1'b0;
    cif.addr = 28'd0;
    cif.wdata = 128'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_c_ready", cif.ready, 0);
    chk("rst_c_rdata", cif.rdata, 0);
    chk("rst_m_read", mif.read, 0);
    chk("rst_m_write", mif.write, 0);
    chk("rst_m_addr", mif.addr, 0);
    chk("rst_m_wdata", mif.wdata, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write
    mem_lat = 3;
    wr(28'h0000010, 128'hA, 1'b1, cyc);
    chk("single_wr_latency", cyc, 1);
    wait_idle("single_wr_drain");
    chk("single_wr_mem", mem[28'h10], 128'hA);

    // Fill and stall
    mem_lat = 10;
    base = writes_done;
    for (int i = 0; i < 4; i++) begin
      wr(28'h100 + 28'(i), 128'h1000 + 128'(i), 1'b1, cyc);
      chk("fill_wr_latency", cyc, 1);
    end
    wr(28'h104, 128'h1004, 1'b1, cyc);
    chk("stall_wr_delayed", (cyc > 1) ? 1 : 0, 1);
    chk("stall_after_first_drain", writes_done - base, 1);
    wait_idle("fill_drain");
    chk("fill_mem_last", mem[28'h104], 128'h1004);

    // Coalesce into a non-head entry while the head drains
    w30 = 0;
    wr(28'h20, 128'hA, 1'b1, cyc);
    wr(28'h30, 128'hB, 1'b0, cyc);
    wr(28'h30, 128'hC, 1'b1, cyc);
    chk("coal_wr_latency", cyc, 1);
    chk("coal_count", dut.count_r, 2);
    wait_idle("coal_drain");
    chk("coal_mem", mem[28'h30], 128'hC);
    chk("coal_single_write", w30, 1);

    // Forwarding from the in-flight head
    rbase = reads_seen;
    wr(28'h40, 128'hD, 1'b1, cyc);
    rd(28'h40, 128'hD, cyc);
    chk("fwd_latency", cyc, 1);
    wait_idle("fwd_drain");
    chk("fwd_no_m_read", reads_seen - rbase, 0);

    // Read miss takes priority over the second pending drain
    mem_lat = 5;
    mem[28'h50] = 128'hE;
    base = writes_done;
    rbase = reads_seen;
    wr(28'h60, 128'hF, 1'b1, cyc);
    wr(28'h70, 128'h70F, 1'b1, cyc);
    rd(28'h50, 128'hE, cyc);
    chk("prio_one_drain_before_read", writes_done - base, 1);
    chk("prio_one_m_read", reads_seen - rbase, 1);
    wait_idle("prio_drain");
    chk("prio_mem_second", mem[28'h70], 128'h70F);

    // Reset mid-drain discards the buffered line
    mem_lat = 20;
    base = writes_done;
    wr(28'h80, 128'h8, 1'b0, cyc);
    n = 0;
    while (!mif.write && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rstd_drain_started", mif.write, 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rstd_m_write_low", mif.write, 0);
    chk("rstd_count", dut.count_r, 0);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("rstd_no_stale_write", writes_done - base, 0);
    chk("rstd_idle", mif.write, 0);

    chk("cq_empty", cq.size(), 0);
    chk("mq_empty", mq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_write_buffer.md
# dmem_write_buffer

Posted line-granular write buffer between the D-cache and the data-side slow memory in CHIP. Cache write-backs are acknowledged in one cycle and drained to slow memory in the background. Reads that hit a buffered line are forwarded from the buffer. Reads that miss are sent to memory ahead of the pending drains. Both faces use the slow-memory request/ready protocol, so the block drops into the existing `mem_*_D` path unchanged.

## Interface
- `DEPTH`, 4: number of line entries (power of two, ≥2).
- `ADDR_W`, 28: line address width (byte address bits [31:4]).
- `DATA_W`, 128: line width.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `c_read`  in  1  cache read request, held until `c_ready`.
- `c_write`  in  1  cache write request, held until `c_ready`.
- `c_addr`  in  ADDR_W  cache line address.
- `c_wdata`  in  DATA_W  cache write line.
- `c_rdata`  out  DATA_W  read line; valid while `c_ready` is high after a read.
- `c_ready`  out  1  one-cycle completion pulse to the cache.
- `m_read`  out  1  memory read request.
- `m_write`  out  1  memory write request.
- `m_addr`  out  ADDR_W  memory line address.
- `m_wdata`  out  DATA_W  memory write line.
- `m_rdata`  in  DATA_W  memory read line; valid with `m_ready`.
- `m_ready`  in  1  memory completion pulse.

## Operation
- FIFO of DEPTH entries; each entry holds addr and data. Head = oldest. Count ranges 0..DEPTH.
- **Write, coalescing**: the write address matches a valid entry that is not the head currently in DRAIN. That entry's data is overwritten in place. Count is unchanged. `c_ready` is asserted next cycle.
- **Write, non-coalescing**: no matching entry, or the only match is the in-flight head. The write is appended at the tail if count < DEPTH, with `c_ready` next cycle. If full, the write is stalled until the drain in flight completes and frees the head. The append and `c_ready` follow on the next cycle.
- **Read hit**: the read address matches any valid entry, including the in-flight head. `c_rdata` returns the youngest match. `c_ready` is asserted next cycle. No memory access is made.
- **Read miss**: any drain in flight is allowed to complete. The downstream FSM then issues READ before the next drain. The value of `m_rdata` at `m_ready` is registered and returned with `c_ready` on the following cycle.
- Downstream FSM states:
  - IDLE: read-miss pending -> READ; else count > 0 -> DRAIN.
  - DRAIN: `m_write` = 1 with the head's addr/data. On `m_ready`, pop the head -> GAP.
  - READ: `m_read` = 1 with the cache addr. On `m_ready` -> GAP.
  - GAP: one idle cycle, requests low -> IDLE.
- `m_addr` and `m_wdata` are held stable throughout DRAIN and READ.
- `c_read` and `c_write` are never both high; if they are, behaviour is undefined.
- **Reset**: all entries are invalidated (buffered writes discarded). FSM -> IDLE. Any downstream request is dropped on that edge.

## Timing
- Reset values: `c_ready` = 0, `c_rdata` = 0, `m_read` = 0, `m_write` = 0, `m_addr` = 0, `m_wdata` = 0.
- All outputs are registered; there are no combinational input-to-output paths.
- `c_ready` is a single-cycle pulse. A request seen on the cycle right after a `c_ready` pulse is ignored, because the cache drops its request on the edge where it samples ready.
- `m_read` and `m_write` go low on the edge where `m_ready` is sampled high. They stay low for at least one cycle (GAP).
- Latencies:
  - Write hit or write with space: 1 cycle.
  - Read hit: 1 cycle.
  - Read miss: remaining drain time + memory latency + 1 GAP + 1 cycle.
- **Simultaneous events**:
  - Drain pop and write append in the same cycle: allowed; count is unchanged.
  - Pop on the cycle a full-buffer write is stalled: the append happens on the next cycle.
  - Coalescing into a non-head entry while the head drains: allowed.
- Pointers wrap modulo DEPTH. Full and empty are decided from count, not from pointer equality.

## Structure
- Package `wb_pkg`: FSM state enum (IDLE, DRAIN, READ, GAP) and default widths ADDR_W / DATA_W.
- Sub-module `wb_match`: combinational address compare across DEPTH entries. It outputs the hit flag and the youngest-match index, with the in-flight head flagged separately.

## Test plan
- **Single write**: reset, write addr 0x0000010, data A -> `c_ready` on cycle 1; later `m_write` with 0x0000010 / A; memory line equals A.
- **Fill and stall**: 5 back-to-back writes to distinct addrs with memory latency 10 -> writes 1–4 acked in 1 cycle; write 5 acked only after the first `m_ready`; memory receives them in order.
- **Coalesce**: write 0x20 = A, then 0x30 = B, then 0x30 = C while 0x20 drains -> count stays 2; memory finally holds 0x30 = C with exactly one write to 0x30.
- **Forwarding**: write 0x40 = D, then immediately read 0x40 -> `c_rdata` = D, 1-cycle latency, no `m_read` issued.
- **Read priority**: two writes pending, read miss to 0x50 (memory holds E) -> the current drain completes, READ is issued before the second drain, `c_rdata` = E, then the remaining drain proceeds.
- **Reset mid-drain**: assert `rst_n` = 0 during DRAIN -> `m_write` low on the next edge, count = 0; after release, no stale write is issued.
